// File: rtl/dna_max_score_tracker.sv
// Frame-wide maximum signed score tracker that snoops the systolic array's matrix write port.
// Optional threshold hit counting is enabled by defining DNA_SCORE_THRESH_EN.
module dna_max_score_tracker #(
  parameter int LANES   = 16,
  parameter int SCORE_W = 32,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_matrix_i,
  input  logic [ADDR_W-1:0]        addr_matrix_i,
  input  logic [LANES*SCORE_W-1:0] matrix_i,
  input  logic                     frame_done_i,
  input  logic                     res_ready_i,
  output logic                     res_valid_o,
  output logic [SCORE_W-1:0]       max_score_o,
  output logic [ADDR_W-1:0]        max_addr_o,
  output logic [3:0]               max_lane_o,
  output logic [CNT_W-1:0]         row_cnt_o,
  output logic                     busy_o,
`ifdef DNA_SCORE_THRESH_EN
  input  logic [SCORE_W-1:0]       thresh_i,
  output logic [CNT_W-1:0]         hit_cnt_o,
`endif
  output logic                     overrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_RESULT} state_t;

  localparam logic signed [SCORE_W-1:0] MOST_NEG = {1'b1, {(SCORE_W-1){1'b0}}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

`ifdef DNA_SCORE_THRESH_EN
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [4:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction
`endif

  state_t                     r_state;
  logic [1:0]                 r_dcnt;
  logic                       r_fd_q;
  logic                       r_res_valid;
  logic signed [SCORE_W-1:0]  r_max_score;
  logic [ADDR_W-1:0]          r_max_addr;
  logic [3:0]                 r_max_lane;
  logic [CNT_W-1:0]           r_row_cnt;
  logic                       r_overrun;

  logic signed [SCORE_W-1:0]  r_row_p1 [LANES];
  logic [ADDR_W-1:0]          r_addr_p1;
  logic                       r_vld_p1;

  logic signed [SCORE_W-1:0]  r_gmax_p2 [4];
  logic [3:0]                 r_glane_p2 [4];
  logic [ADDR_W-1:0]          r_addr_p2;
  logic                       r_vld_p2;

  logic signed [SCORE_W-1:0]  w_gmax [4];
  logic [3:0]                 w_glane [4];
  logic signed [SCORE_W-1:0]  w_fmax;
  logic [3:0]                 w_flane;
  logic                       w_fd_rise;
  logic                       w_accept;
  logic                       w_upd;

`ifdef DNA_SCORE_THRESH_EN
  logic [4:0]                 w_hits;
  logic [4:0]                 r_hits_p2;
  logic [CNT_W-1:0]           r_hit_cnt;
`endif

  assign w_fd_rise = frame_done_i & ~r_fd_q;
  assign w_accept  = w_matrix_i & ((r_state == S_IDLE) | (r_state == S_ACCUM));

  // S2 combinational: per-group 4:1 max; strict > keeps the lowest lane on ties
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      w_gmax[g]  = r_row_p1[4*g];
      w_glane[g] = 4'(4*g);
      for (int j = 1; j < 4; j++) begin
        if (r_row_p1[4*g+j] > w_gmax[g]) begin
          w_gmax[g]  = r_row_p1[4*g+j];
          w_glane[g] = 4'(4*g+j);
        end
      end
    end
  end

`ifdef DNA_SCORE_THRESH_EN
  always_comb begin
    w_hits = '0;
    for (int k = 0; k < LANES; k++)
      if (r_row_p1[k] >= $signed(thresh_i)) w_hits = w_hits + 5'd1;
  end
`endif

  // S3 combinational: final 4:1 max, then strict compare against the running max
  always_comb begin
    w_fmax  = r_gmax_p2[0];
    w_flane = r_glane_p2[0];
    for (int g = 1; g < 4; g++) begin
      if (r_gmax_p2[g] > w_fmax) begin
        w_fmax  = r_gmax_p2[g];
        w_flane = r_glane_p2[g];
      end
    end
    w_upd = r_vld_p2 && (w_fmax > r_max_score);
  end

  // S1 -> S2 data registers
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++)
      r_row_p1[k] <= matrix_i[k*SCORE_W +: SCORE_W];
    r_addr_p1 <= addr_matrix_i;
    for (int g = 0; g < 4; g++) begin
      r_gmax_p2[g]  <= w_gmax[g];
      r_glane_p2[g] <= w_glane[g];
    end
    r_addr_p2 <= r_addr_p1;
`ifdef DNA_SCORE_THRESH_EN
    r_hits_p2 <= w_hits;
`endif
    r_fd_q <= frame_done_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dcnt      <= '0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_res_valid <= 1'b0;
      r_max_score <= MOST_NEG;
      r_max_addr  <= '0;
      r_max_lane  <= '0;
      r_row_cnt   <= '0;
      r_overrun   <= 1'b0;
`ifdef DNA_SCORE_THRESH_EN
      r_hit_cnt   <= '0;
`endif
    end else begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      if (w_accept) r_row_cnt <= sat_inc(r_row_cnt);
      if (w_matrix_i && !w_accept) r_overrun <= 1'b1;
      if (w_upd) begin
        r_max_score <= w_fmax;
        r_max_addr  <= r_addr_p2;
        r_max_lane  <= w_flane;
      end
`ifdef DNA_SCORE_THRESH_EN
      if (r_vld_p2) r_hit_cnt <= sat_add(r_hit_cnt, r_hits_p2);
`endif
      case (r_state)
        S_IDLE: begin
          r_dcnt <= '0;
          if (w_fd_rise) begin
            // A row arriving with the edge still needs the drain window
            if (w_matrix_i) begin
              r_state <= S_DRAIN;
            end else begin
              r_state     <= S_RESULT;
              r_res_valid <= 1'b1;
            end
          end else if (w_matrix_i) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          r_dcnt <= '0;
          if (w_fd_rise) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_dcnt == 2'd2) begin
            r_state     <= S_RESULT;
            r_res_valid <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 2'd1;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            r_state     <= S_IDLE;
            r_res_valid <= 1'b0;
            r_max_score <= MOST_NEG;
            r_max_addr  <= '0;
            r_max_lane  <= '0;
            r_row_cnt   <= '0;
`ifdef DNA_SCORE_THRESH_EN
            r_hit_cnt   <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res_valid_o = r_res_valid;
  assign max_score_o = r_max_score;
  assign max_addr_o  = r_max_addr;
  assign max_lane_o  = r_max_lane;
  assign row_cnt_o   = r_row_cnt;
  assign overrun_o   = r_overrun;
  assign busy_o      = ((r_state == S_ACCUM) && (r_row_cnt != '0)) || (r_state == S_DRAIN);
`ifdef DNA_SCORE_THRESH_EN
  assign hit_cnt_o   = r_hit_cnt;
`endif

endmodule

// File: tb/tb_dna_max_score_tracker.sv
// Directed self-checking bench for dna_max_score_tracker.
module tb_dna_max_score_tracker;

  logic         clk = 1'b0;
  logic         rst;
  logic         w_matrix_i;
  logic [31:0]  addr_matrix_i;
  logic [511:0] matrix_i;
  logic         frame_done_i;
  logic         res_ready_i;
  logic         res_valid_o;
  logic [31:0]  max_score_o;
  logic [31:0]  max_addr_o;
  logic [3:0]   max_lane_o;
  logic [15:0]  row_cnt_o;
  logic         busy_o;
  logic         overrun_o;
`ifdef DNA_SCORE_THRESH_EN
  logic [31:0]  thresh_i;
  logic [15:0]  hit_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dna_max_score_tracker dut (
    .clk(clk), .rst(rst), .w_matrix_i(w_matrix_i), .addr_matrix_i(addr_matrix_i),
    .matrix_i(matrix_i), .frame_done_i(frame_done_i), .res_ready_i(res_ready_i),
    .res_valid_o(res_valid_o), .max_score_o(max_score_o), .max_addr_o(max_addr_o),
    .max_lane_o(max_lane_o), .row_cnt_o(row_cnt_o), .busy_o(busy_o),
`ifdef DNA_SCORE_THRESH_EN
    .thresh_i(thresh_i), .hit_cnt_o(hit_cnt_o),
`endif
    .overrun_o(overrun_o)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic [31:0] addr, input logic [511:0] row);
    w_matrix_i = 1'b1; addr_matrix_i = addr; matrix_i = row;
    tick();
    w_matrix_i = 1'b0; matrix_i = '0;
  endtask

  task automatic pulse_fd();
    frame_done_i = 1'b1; tick(); frame_done_i = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      if (res_valid_o) got = 1'b1; else tick();
    end
  endtask

  task automatic handshake();
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0h want 0", res_valid_o); end
    n_cmp++; if (max_score_o !== 32'h8000_0000) begin n_bad++; $display("FAIL reset_max got %0h want 80000000", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", max_addr_o); end
    n_cmp++; if (max_lane_o !== 4'd0) begin n_bad++; $display("FAIL reset_lane got %0h want 0", max_lane_o); end
    n_cmp++; if (row_cnt_o !== 16'd0) begin n_bad++; $display("FAIL reset_rowcnt got %0h want 0", row_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0h want 0", busy_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %0h want 0", overrun_o); end
  endtask

  task automatic test_single_row();
    logic [511:0] m; bit got;
    m = '0; m[5*32 +: 32] = 32'd40;
    strobe(32'd7, m);
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy got %0h want 1", busy_o); end
    pulse_fd();
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0h want 1", got); end
    n_cmp++; if (max_score_o !== 32'd40) begin n_bad++; $display("FAIL single_max got %0d want 40", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd7) begin n_bad++; $display("FAIL single_addr got %0d want 7", max_addr_o); end
    n_cmp++; if (max_lane_o !== 4'd5) begin n_bad++; $display("FAIL single_lane got %0d want 5", max_lane_o); end
    n_cmp++; if (row_cnt_o !== 16'd1) begin n_bad++; $display("FAIL single_rowcnt got %0d want 1", row_cnt_o); end
    handshake();
    n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("FAIL single_hs_valid got %0h want 0", res_valid_o); end
    n_cmp++; if (max_score_o !== 32'h8000_0000) begin n_bad++; $display("FAIL single_hs_max got %0h want 80000000", max_score_o); end
    n_cmp++; if (row_cnt_o !== 16'd0) begin n_bad++; $display("FAIL single_hs_rowcnt got %0d want 0", row_cnt_o); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] m0, m1, m2; bit got;
    m0 = '0; m0[2*32 +: 32] = 32'd10;
    m1 = '0; m1[3*32 +: 32] = 32'd25; m1[9*32 +: 32] = 32'd25;
    m2 = '0; m2[0 +: 32] = 32'd25;
    w_matrix_i = 1'b1;
    addr_matrix_i = 32'd0; matrix_i = m0; tick();
    addr_matrix_i = 32'd1; matrix_i = m1; tick();
    addr_matrix_i = 32'd2; matrix_i = m2; tick();
    w_matrix_i = 1'b0; matrix_i = '0;
    pulse_fd();
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_valid got %0h want 1", got); end
    n_cmp++; if (max_score_o !== 32'd25) begin n_bad++; $display("FAIL b2b_max got %0d want 25", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd1) begin n_bad++; $display("FAIL b2b_addr got %0d want 1", max_addr_o); end
    n_cmp++; if (max_lane_o !== 4'd3) begin n_bad++; $display("FAIL b2b_lane got %0d want 3", max_lane_o); end
    n_cmp++; if (row_cnt_o !== 16'd3) begin n_bad++; $display("FAIL b2b_rowcnt got %0d want 3", row_cnt_o); end
    handshake();
  endtask

  task automatic test_negative_and_empty();
    logic [511:0] m; bit got;
    for (int k = 0; k < 16; k++) m[k*32 +: 32] = 32'(-(3 + k));
    strobe(32'd5, m);
    pulse_fd();
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL neg_valid got %0h want 1", got); end
    n_cmp++; if (max_score_o !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL neg_max got %0h want fffffffd", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd5) begin n_bad++; $display("FAIL neg_addr got %0d want 5", max_addr_o); end
    n_cmp++; if (max_lane_o !== 4'd0) begin n_bad++; $display("FAIL neg_lane got %0d want 0", max_lane_o); end
    handshake();
    tick();
    pulse_fd();
    wait_valid(6, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL empty_valid got %0h want 1", got); end
    n_cmp++; if (max_score_o !== 32'h8000_0000) begin n_bad++; $display("FAIL empty_max got %0h want 80000000", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd0) begin n_bad++; $display("FAIL empty_addr got %0d want 0", max_addr_o); end
    n_cmp++; if (row_cnt_o !== 16'd0) begin n_bad++; $display("FAIL empty_rowcnt got %0d want 0", row_cnt_o); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [511:0] m, big; bit got; bit stable;
    m = '0; m[1*32 +: 32] = 32'd5;
    big = '0; big[0 +: 32] = 32'd1000;
    strobe(32'd3, m);
    pulse_fd();
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %0h want 1", got); end
    stable = 1'b1;
    w_matrix_i = 1'b1; addr_matrix_i = 32'd9; matrix_i = big;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid_o !== 1'b1 || max_score_o !== 32'd5 || max_addr_o !== 32'd3 ||
          max_lane_o !== 4'd1 || row_cnt_o !== 16'd1) stable = 1'b0;
    end
    w_matrix_i = 1'b0; matrix_i = '0;
    tick(); tick(); tick();
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL bp_stable got %0h want 1", stable); end
    n_cmp++; if (max_score_o !== 32'd5) begin n_bad++; $display("FAIL bp_max got %0d want 5", max_score_o); end
    n_cmp++; if (row_cnt_o !== 16'd1) begin n_bad++; $display("FAIL bp_rowcnt got %0d want 1", row_cnt_o); end
    n_cmp++; if (overrun_o !== 1'b1) begin n_bad++; $display("FAIL bp_overrun got %0h want 1", overrun_o); end
    handshake();
    n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_idle_valid got %0h want 0", res_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL bp_idle_busy got %0h want 0", busy_o); end
    n_cmp++; if (overrun_o !== 1'b1) begin n_bad++; $display("FAIL bp_overrun_sticky got %0h want 1", overrun_o); end
  endtask

  task automatic test_same_cycle_done();
    logic [511:0] m0, m1; bit got;
    m0 = '0; m0[5*32 +: 32] = 32'd7;
    m1 = '0; m1[0 +: 32] = 32'd99;
    strobe(32'd1, m0);
    frame_done_i = 1'b1;
    strobe(32'd2, m1);
    frame_done_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL same_drain_busy got %0h want 1", busy_o); end
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL same_valid got %0h want 1", got); end
    n_cmp++; if (max_score_o !== 32'd99) begin n_bad++; $display("FAIL same_max got %0d want 99", max_score_o); end
    n_cmp++; if (max_addr_o !== 32'd2) begin n_bad++; $display("FAIL same_addr got %0d want 2", max_addr_o); end
    n_cmp++; if (row_cnt_o !== 16'd2) begin n_bad++; $display("FAIL same_rowcnt got %0d want 2", row_cnt_o); end
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    logic [511:0] m; bit seen;
    m = '0; m[0 +: 32] = 32'd50;
    strobe(32'd4, m);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid_o) seen = 1'b1;
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %0h want 0", seen); end
    n_cmp++; if (max_score_o !== 32'h8000_0000) begin n_bad++; $display("FAIL rstmid_max got %0h want 80000000", max_score_o); end
    n_cmp++; if (row_cnt_o !== 16'd0) begin n_bad++; $display("FAIL rstmid_rowcnt got %0d want 0", row_cnt_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0h want 0", busy_o); end
    n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_overrun got %0h want 0", overrun_o); end
  endtask

`ifdef DNA_SCORE_THRESH_EN
  task automatic test_threshold();
    logic [511:0] m0, m1; bit got;
    thresh_i = 32'd20;
    m0 = '0; m0[0 +: 32] = 32'd20; m0[1*32 +: 32] = 32'd21; m0[2*32 +: 32] = 32'd30;
    m0[3*32 +: 32] = 32'd19;
    m1 = '0;
    for (int k = 4; k < 8; k++) m1[k*32 +: 32] = 32'd25;
    strobe(32'd0, m0);
    strobe(32'd1, m1);
    pulse_fd();
    wait_valid(12, got);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL thr_valid got %0h want 1", got); end
    n_cmp++; if (hit_cnt_o !== 16'd7) begin n_bad++; $display("FAIL thr_hits got %0d want 7", hit_cnt_o); end
    handshake();
    n_cmp++; if (hit_cnt_o !== 16'd0) begin n_bad++; $display("FAIL thr_clear got %0d want 0", hit_cnt_o); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; w_matrix_i = 1'b0; addr_matrix_i = '0; matrix_i = '0;
    frame_done_i = 1'b0; res_ready_i = 1'b0;
`ifdef DNA_SCORE_THRESH_EN
    thresh_i = 32'd20;
`endif
    test_reset();
    test_single_row();
    test_back_to_back();
    test_negative_and_empty();
    test_backpressure();
    test_same_cycle_done();
    test_reset_mid_frame();
`ifdef DNA_SCORE_THRESH_EN
    test_threshold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
